sext_pipe: RTL and testbench

SEXT_PIPE -- requirements
Module: sext_pipe

---
 rtl/sext_pkg.sv | 28 ++
 rtl/sext_decode.sv | 57 +++++
 rtl/sext_pipe.sv | 90 +++++++++
 tb/tb_sext_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sext_pkg.sv
// Shared definitions for the immediate-extension pipe: op encodings and FIFO entry layout.
// Entries are sized for the widest build (XLEN=64, tags up to 16 bits); users slice down.
package sext_pkg;

    localparam int IMM_MAX = 64;
    localparam int TAG_MAX = 16;

    typedef enum logic [3:0] {
        OP_R    = 4'd0,
        OP_I    = 4'd1,
        OP_MOVE = 4'd2,
        OP_S    = 4'd3,
        OP_B    = 4'd4,
        OP_U    = 4'd5,
        OP_J    = 4'd6,
        OP_ZIMM = 4'd7,
        OP_CI   = 4'd8,
        OP_CJ   = 4'd9,
        OP_CB   = 4'd10
    } op_e;

    typedef struct packed {
        logic [IMM_MAX-1:0] imm;
        logic [TAG_MAX-1:0] tag;
        logic               err;
    } entry_t;

endpackage

// File: rtl/sext_decode.sv
// Combinational immediate extractor/extender; zero latency, no flow control.
// Compressed formats CI/CJ/CB are decoded only when SEXT_RVC_EN is defined.
module sext_decode
    import sext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Every format fits in 32 bits; the 64-bit build only sign-extends bit 31.
    logic [31:0] v;
    logic        unused_inst;

    assign unused_inst = ^inst;

    always_comb begin
        v   = '0;
        err = 1'b0;
        case (op)
            OP_R:    v = '0;
            OP_I:    v = {{20{inst[31]}}, inst[31:20]};
            OP_MOVE: begin
                if (XLEN == 64) v = {26'b0, inst[25:20]};
                else            v = {27'b0, inst[24:20]};
            end
            OP_S:    v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_B:    v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_U:    v = {inst[31:12], 12'b0};
            OP_J:    v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            OP_ZIMM: v = {27'b0, inst[19:15]};
`ifdef SEXT_RVC_EN
            OP_CI:   v = {{26{inst[12]}}, inst[12], inst[6:2]};
            OP_CJ:   v = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                          inst[2], inst[11], inst[5:3], 1'b0};
            OP_CB:   v = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10],
                          inst[4:3], 1'b0};
`endif
            default: begin
                v   = '0;
                err = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign imm = {{32{v[31]}}, v};
        end else begin : g_x32
            assign imm = v;
        end
    endgenerate

endmodule

// File: rtl/sext_pipe.sv
// Immediate extender with a 2-entry skid FIFO; 1 cycle accept-to-head, 1/cycle sustained.
// in_ready comes only from the registered count (no out_ready path); SEXT_RVC_EN adds CI/CJ/CB.
module sext_pipe
    import sext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    logic [XLEN-1:0] dec_imm;
    logic            dec_err;
    entry_t          mem [2];
    entry_t          wr_ent;
    entry_t          head;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;
    logic            unused_head;

    sext_decode #(.XLEN(XLEN)) u_dec (
        .op   (in_op),
        .inst (in_inst),
        .imm  (dec_imm),
        .err  (dec_err)
    );

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ent     = '0;
        wr_ent.imm = IMM_MAX'(dec_imm);
        wr_ent.tag = TAG_MAX'(in_tag);
        wr_ent.err = dec_err;
    end

    // Reset also clears storage; flush only drops the bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_ent;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head        = mem[rd_ptr];
    assign unused_head = ^{head.imm, head.tag};

    assign out_imm = out_valid ? head.imm[XLEN-1:0]  : '0;
    assign out_tag = out_valid ? head.tag[TAG_W-1:0] : '0;
    assign out_err = out_valid ? head.err            : 1'b0;

endmodule

// File: tb/tb_sext_pipe.sv
// Drives an XLEN=32 and an XLEN=64 sext_pipe with shared stimulus; a queue model scores both.
module tb_sext_pipe;

    typedef struct packed {
        logic [31:0] i32;
        logic [63:0] i64;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [3:0]  in_op;
    logic [31:0] in_inst;
    logic [4:0]  in_tag;

    logic        rdy32, vld32, err32, rdy64, vld64, err64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    sext_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_op(in_op), .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld32),
        .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_err(err32)
    );

    sext_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_op(in_op), .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld64),
        .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_err(err64)
    );

    // Immediate value from the instruction-set definition, as plain signed arithmetic.
    function automatic exp_t ref_of(input logic [3:0] op, input logic [31:0] x, input logic [4:0] tg);
        exp_t   e;
        longint v;
        v     = 0;
        e.err = 1'b0;
        e.tag = tg;
        case (op)
            4'd0: v = 0;
            4'd1: v = longint'($signed(x[31:20]));
            4'd2: v = 0;
            4'd3: v = longint'($signed({x[31:25], x[11:7]}));
            4'd4: v = longint'($signed({x[31], x[7], x[30:25], x[11:8]})) * longint'(2);
            4'd5: v = longint'($signed(x[31:12])) * longint'(4096);
            4'd6: v = longint'($signed({x[31], x[19:12], x[20], x[30:21]})) * longint'(2);
            4'd7: v = longint'(x[19:15]);
`ifdef SEXT_RVC_EN
            4'd8: v = longint'($signed({x[12], x[6:2]}));
            4'd9: v = longint'($signed({x[12], x[8], x[10:9], x[6], x[7], x[2], x[11], x[5:3]})) * longint'(2);
            4'd10: v = longint'($signed({x[12], x[6:5], x[2], x[11:10], x[4:3]})) * longint'(2);
`endif
            default: e.err = 1'b1;
        endcase
        e.i32 = v[31:0];
        e.i64 = v;
        if (op == 4'd2) begin
            e.i32 = {27'b0, x[24:20]};
            e.i64 = {58'b0, x[25:20]};
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] x,
                         input logic [4:0] tg, input logic ordy, input logic fl);
        in_valid  = v;
        in_op     = op;
        in_inst   = x;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One clock: the model sees the same inputs the DUTs sample on the edge.
    task automatic cycle();
        bit can_push;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            can_push = (q.size() < 2);
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && can_push) q.push_back(ref_of(in_op, in_inst, in_tag));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'd1, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0);
        total++; if (vld32 !== 1'b0) begin bad++; $display("FAIL reset_vld32 got=%b want=0", vld32); end
        total++; if (vld64 !== 1'b0) begin bad++; $display("FAIL reset_vld64 got=%b want=0", vld64); end
        total++; if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b/%b want=1/1", rdy32, rdy64); end
        total++; if (imm32 !== 32'h0) begin bad++; $display("FAIL reset_imm32 got=%h want=0", imm32); end
        total++; if (imm64 !== 64'h0) begin bad++; $display("FAIL reset_imm64 got=%h want=0", imm64); end
        total++; if (err32 !== 1'b0 || tag32 !== 5'd0) begin bad++; $display("FAIL reset_err_tag got=%b/%h want=0/0", err32, tag32); end
    endtask

    task automatic test_i_type();
        drive(1'b1, 4'd1, 32'hFFF0_0093, 5'd3, 1'b1, 1'b0);
        total++; if (vld32 !== 1'b0) begin bad++; $display("FAIL i_early_vld got=%b want=0", vld32); end
        cycle();
        drive(1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0);
        total++; if (vld32 !== 1'b1) begin bad++; $display("FAIL i_vld got=%b want=1", vld32); end
        total++; if (imm32 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL i_imm32 got=%h want=ffffffff", imm32); end
        total++; if (err32 !== 1'b0 || tag32 !== 5'd3) begin bad++; $display("FAIL i_err_tag got=%b/%h want=0/3", err32, tag32); end
        cycle();
        total++; if (vld32 !== 1'b0) begin bad++; $display("FAIL i_drained got=%b want=0", vld32); end
    endtask

    task automatic test_xlen64();
        drive(1'b1, 4'd5, 32'h8000_02B7, 5'd7, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 4'd2, 32'h03F0_0000, 5'd8, 1'b1, 1'b0);
        total++; if (imm64 !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL u_imm64 got=%h want=ffffffff80000000", imm64); end
        total++; if (imm32 !== 32'h8000_0000) begin bad++; $display("FAIL u_imm32 got=%h want=80000000", imm32); end
        cycle();
        drive(1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0);
        total++; if (imm64 !== 64'h3F || err64 !== 1'b0) begin bad++; $display("FAIL move_imm64 got=%h/%b want=3f/0", imm64, err64); end
        total++; if (imm32 !== 32'h1F) begin bad++; $display("FAIL move_imm32 got=%h want=1f", imm32); end
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] b [3];
        int accepted = 0;
        int got      = 0;
        bit r;
        for (int k = 0; k < 3; k++) b[k] = $urandom;
        for (int c = 0; c < 6 && accepted < 3; c++) begin
            drive(1'b1, 4'd4, b[accepted], 5'(accepted), 1'b0, 1'b0);
            r = rdy32;
            cycle();
            if (r) accepted++;
        end
        total++; if (accepted != 2 || rdy32 !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%0d/%b want=2/0", accepted, rdy32); end
        for (int c = 0; c < 12 && got < 3; c++) begin
            logic v;
            int   idx;
            exp_t e;
            v   = (accepted < 3);
            idx = v ? accepted : 2;
            drive(v, 4'd4, b[idx], 5'(idx), 1'b1, 1'b0);
            r = rdy32;
            if (vld32) begin
                e = ref_of(4'd4, b[got], 5'(got));
                total++;
                if (imm32 !== e.i32 || tag32 !== e.tag || imm64 !== e.i64) begin
                    bad++; $display("FAIL b2b_order idx=%0d got=%h/%h want=%h/%h", got, imm32, tag32, e.i32, e.tag);
                end
                got++;
            end
            cycle();
            if (v && r) accepted++;
        end
        total++; if (got != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", got); end
        drive(1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0);
        cycle();
    endtask

    task automatic test_flush();
        drive(1'b1, 4'd1, 32'h1230_0000, 5'd1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 4'd1, 32'h4560_0000, 5'd2, 1'b0, 1'b0);
        cycle();
        total++; if (rdy32 !== 1'b0 || vld32 !== 1'b1) begin bad++; $display("FAIL flush_full got=%b/%b want=0/1", rdy32, vld32); end
        drive(1'b1, 4'd1, 32'h7890_0000, 5'd3, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0);
        total++; if (vld32 !== 1'b0 || rdy32 !== 1'b1) begin bad++; $display("FAIL flush_clear got=%b/%b want=0/1", vld32, rdy32); end
        cycle();
        total++; if (vld32 !== 1'b0 || vld64 !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b/%b want=0/0", vld32, vld64); end
    endtask

    task automatic test_rvc();
        logic want_err;
`ifdef SEXT_RVC_EN
        want_err = 1'b0;
`else
        want_err = 1'b1;
`endif
        drive(1'b1, 4'd9, 32'h0000_A001, 5'd9, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 4'd11, 32'hFFFF_FFFF, 5'd11, 1'b1, 1'b0);
        total++; if (imm32 !== 32'h0 || err32 !== want_err) begin bad++; $display("FAIL rvc_cj got=%h/%b want=0/%b", imm32, err32, want_err); end
        cycle();
        drive(1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0);
        total++; if (imm64 !== 64'h0 || err64 !== 1'b1) begin bad++; $display("FAIL op11_err got=%h/%b want=0/1", imm64, err64); end
        cycle();
    endtask

    task automatic test_rst_mid();
        drive(1'b1, 4'd3, 32'hFE00_0F80, 5'd4, 1'b0, 1'b0);
        cycle();
        total++; if (vld32 !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b want=1", vld32); end
        rst = 1'b1;
        drive(1'b1, 4'd1, 32'hFFF0_0000, 5'd5, 1'b1, 1'b1);
        cycle();
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 5'd0, 1'b1, 1'b0);
        total++; if (vld32 !== 1'b0 || imm32 !== 32'h0) begin bad++; $display("FAIL rstmid got=%b/%h want=0/0", vld32, imm32); end
        total++; if (vld64 !== 1'b0 || imm64 !== 64'h0) begin bad++; $display("FAIL rstmid64 got=%b/%h want=0/0", vld64, imm64); end
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            total++;
            if (rdy32 !== (q.size() < 2) || rdy64 !== (q.size() < 2)) begin
                bad++; $display("FAIL rnd_rdy cyc=%0d got=%b/%b want=%b", c, rdy32, rdy64, q.size() < 2);
            end
            total++;
            if (vld32 !== (q.size() != 0) || vld64 !== (q.size() != 0)) begin
                bad++; $display("FAIL rnd_vld cyc=%0d got=%b/%b want=%b", c, vld32, vld64, q.size() != 0);
            end
            if (q.size() != 0) begin
                total++;
                if (imm32 !== q[0].i32 || tag32 !== q[0].tag || err32 !== q[0].err) begin
                    bad++; $display("FAIL rnd_head32 cyc=%0d got=%h/%h/%b want=%h/%h/%b", c, imm32, tag32, err32, q[0].i32, q[0].tag, q[0].err);
                end
                total++;
                if (imm64 !== q[0].i64 || tag64 !== q[0].tag || err64 !== q[0].err) begin
                    bad++; $display("FAIL rnd_head64 cyc=%0d got=%h/%h/%b want=%h/%h/%b", c, imm64, tag64, err64, q[0].i64, q[0].tag, q[0].err);
                end
            end
            rst = ($urandom_range(0, 80) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 11)), $urandom, 5'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
            cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_i_type();
        test_xlen64();
        test_back_to_back();
        test_flush();
        test_rvc();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
